merge21_arbiter: RTL
====================

# merge21_arbiter

Clocked 2-to-1 packet merge stage for the NoC router output path: takes the two flit streams produced by a 1-to-2 decoder stage from two different input ports, arbitrates round-robin at packet granularity, and forwards whole packets onto one output channel through a 2-entry output FIFO. It sits directly downstream of the decoder outputs, one per router output port. It never interleaves flits of different packets.

## Interface
- W, 9, flit width; bit W-1 is the tail marker (1 = last flit of packet), bits W-2:0 are the header/payload.
- CNT_W, 16, width of the forwarded-packet counter.
- CLK  input  1  sole clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- in0_data  input  W  flit from upstream channel 0.
- in0_valid  input  1  in0_data valid.
- in0_ready  output  1  stage accepts in0 flit this cycle.
- in1_data  input  W  flit from upstream channel 1.
- in1_valid  input  1  in1_data valid.
- in1_ready  output  1  stage accepts in1 flit this cycle.
- out_data  output  W  head of output FIFO.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accepts out_data this cycle.
- pkt_count  output  CNT_W  number of tail flits dequeued on out, wraps.
- busy  output  1  state != IDLE (packet in progress).

## Operation
- Transfer on any channel occurs when valid && ready on the same rising edge.
- State machine: IDLE, LOCK0, LOCK1; priority bit prio.
- IDLE: winner = channel with valid; if both valid, winner = prio. Winner's ready = (fifo_count < 2); loser's ready = 0. On accepted flit: tail=1 -> stay IDLE, prio <= ~winner; tail=0 -> LOCK<winner>.
- LOCKx: inx_ready = (fifo_count < 2); other ready = 0 regardless of its valid. On accepted tail flit -> IDLE, prio <= ~x. Non-tail flits keep LOCKx.
- Single-flit packets (tail set on header) never leave IDLE.
- Output FIFO, 2 entries: enqueue on accepted input flit, dequeue on out_valid && out_ready. Simultaneous enq/deq at count 1 -> count stays 1, order preserved. Enq never occurs at count 2 (ready low).
- pkt_count increments by 1 on each dequeue with out_data[W-1]=1; 0xFFFF + 1 -> 0x0000.
- in*_ready depends only on state, prio, fifo_count and in*_valid; no combinational path from out_ready to any in*_ready.
- Flit data passes unmodified.

## Timing
- Reset values: state IDLE, prio 0, fifo_count 0, out_valid 0, out_data 0, pkt_count 0, busy 0; in*_ready 0 while RESET high.
- RESET mid-packet: FIFO contents and partial packet discarded, arbitration restarts in IDLE; upstream is reset in the same cycle by system contract.
- Latency: flit accepted at edge t is on out_data with out_valid=1 after edge t (visible cycle t+1) if FIFO was empty.
- Throughput: 1 flit/cycle sustained while out_ready=1.
- out_ready stalled: at most 2 flits accepted, then all in*_ready=0 until a dequeue.
- Arbitration turnaround: zero bubble; after tail from channel x in cycle t, channel ~x header may be accepted in cycle t+1.
- out_data/out_valid hold stable while out_valid && !out_ready.

## Structure
- Shared package noc_pkg: FLIT_W=9, TAIL_BIT=FLIT_W-1, merge_state_t enum {IDLE, LOCK0, LOCK1}, flit_t typedef.
- One sub-module: flit_fifo2 (2-entry synchronous FIFO, count output, same CLK/RESET).
- Arbiter FSM, prio register and pkt_count in top level.

## Test plan
- Reset then idle: all outputs 0; drive in0 single flit 0x1A5 (tail) -> out_data=0x1A5 next cycle, pkt_count=1, state back IDLE.
- Both channels valid from reset, 3-flit packets (0x001,0x002,0x103 on in0; 0x011,0x012,0x113 on in1): out sequence in0 packet then in1 packet, no interleave, 6 consecutive cycles, pkt_count=2.
- Continuous single-flit traffic on both: grants alternate 0,1,0,1; in1 flit accepted cycle after in0 flit.
- out_ready=0 for 5 cycles with in0 streaming: exactly 2 flits accepted, in0_ready=0 afterwards, out_data stable; release -> order preserved, no loss.
- Assert RESET mid-packet in LOCK1 with 1 flit queued: next cycle out_valid=0, busy=0, pkt_count=0, new in0 header granted immediately.
- Drive 65536 single-flit packets: pkt_count wraps to 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit layout and merge-stage arbiter states.
package noc_pkg;

    localparam int FLIT_W   = 9;
    localparam int TAIL_BIT = FLIT_W - 1;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } merge_state_t;

endpackage

// File: rtl/flit_fifo2.sv
// Two-entry synchronous FIFO; entry0 is always the head, so the head
// output is a plain register and stays stable while the FIFO is not popped.
module flit_fifo2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enq,
    input  logic [W-1:0] enq_data,
    input  logic         deq,
    output logic [W-1:0] head_data,
    output logic         valid,
    output logic [1:0]   count
);

    logic [W-1:0] entry0;
    logic [W-1:0] entry1;
    logic         enq_ok;
    logic         deq_ok;

    // Requests that would overflow or underflow are ignored.
    assign enq_ok = enq && (count != 2'd2);
    assign deq_ok = deq && (count != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            case ({enq_ok, deq_ok})
                2'b10: begin
                    if (count == 2'd0) entry0 <= enq_data;
                    else               entry1 <= enq_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                // Simultaneous push and pop: occupancy unchanged, new flit lands behind the survivor.
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0 <= enq_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= enq_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data = entry0;
    assign valid     = (count != 2'd0);

endmodule

// File: rtl/merge21_arbiter.sv
// 2-to-1 packet merge stage: round-robin arbitration at packet granularity
// feeding a 2-entry output FIFO; packets from the two inputs never interleave.
module merge21_arbiter
    import noc_pkg::*;
#(
    parameter int W     = FLIT_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [W-1:0]     in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pkt_count,
    output logic             busy
);

    merge_state_t state_q;
    merge_state_t state_d;
    logic         prio_q;
    logic         prio_d;
    logic [1:0]   fifo_count;
    logic         fifo_room;
    logic         accept0;
    logic         accept1;
    logic         enq;
    logic [W-1:0] enq_data;
    logic         deq;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // A tail flit releases the lock and hands priority to the other channel.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        if (accept0) begin
            if (in0_data[W-1]) begin
                state_d = IDLE;
                prio_d  = 1'b1;
            end else begin
                state_d = LOCK0;
            end
        end else if (accept1) begin
            if (in1_data[W-1]) begin
                state_d = IDLE;
                prio_d  = 1'b0;
            end else begin
                state_d = LOCK1;
            end
        end
    end

    // Ready never looks at out_ready, only at local FIFO occupancy.
    always_comb begin
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (in0_valid && (!in1_valid || !prio_q)) in0_ready = fifo_room;
                    else if (in1_valid)                       in1_ready = fifo_room;
                end
                LOCK0:   in0_ready = fifo_room;
                LOCK1:   in1_ready = fifo_room;
                default: ;
            endcase
        end
    end

    assign fifo_room = (fifo_count < 2'd2);
    assign accept0   = in0_valid && in0_ready;
    assign accept1   = in1_valid && in1_ready;
    assign enq       = accept0 || accept1;
    assign enq_data  = accept1 ? in1_data : in0_data;
    assign deq       = out_valid && out_ready;
    assign busy      = (state_q != IDLE);

    flit_fifo2 #(.W(W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .enq       (enq),
        .enq_data  (enq_data),
        .deq       (deq),
        .head_data (out_data),
        .valid     (out_valid),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset)                        pkt_count <= '0;
        else if (deq && out_data[W-1])    pkt_count <= pkt_count + 1'b1;
    end

endmodule
